// File: rtl/pc_fetch_master.sv
// Avalon-MM instruction fetch master for the 32-word pc_ on-chip RAM slave.
// Prefetches sequential words, which are flushed on redirect/stop, into a small valid/ready FIFO.
module pc_fetch_master #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stop,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              busy,
  output logic [ADDR_W-1:0] pc_address,
  output logic              pc_chipselect,
  output logic              pc_clken,
  output logic              pc_write,
  output logic [DATA_W-1:0] pc_writedata,
  output logic [3:0]        pc_byteenable,
  output logic              pc_debugaccess,
  input  logic [DATA_W-1:0] pc_readdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] tag;
  logic              rd_pending;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;

  logic              pop;
  logic              push;
  logic              flush;
  logic              issue;
  logic [CW:0]       in_flight;

  // start while running behaves as a redirect, so it flushes and blocks issue too
  always_comb begin
    pop       = instr_valid & instr_ready;
    flush     = (state == RUN) & (stop | redirect_valid | start);
    push      = rd_pending & ~flush;
    in_flight = {1'b0, count} + (CW+1)'(rd_pending) - (CW+1)'(pop);
    issue     = (state == RUN) & ~flush & (in_flight < (CW+1)'(DEPTH));
  end

  assign instr_valid    = (count != '0);
  assign instr_data     = instr_valid ? data_mem[rd_ptr] : '0;
  assign instr_addr     = instr_valid ? addr_mem[rd_ptr] : '0;
  assign busy           = (state == RUN);
  assign pc_address     = pc;
  assign pc_chipselect  = issue;
  assign pc_clken       = 1'b1;
  assign pc_write       = 1'b0;
  assign pc_writedata   = '0;
  assign pc_byteenable  = 4'hF;
  assign pc_debugaccess = 1'b0;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state      <= IDLE;
      pc         <= '0;
      tag        <= '0;
      rd_pending <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            pc    <= start_addr;
          end
        end
        RUN: begin
          if (stop)                state <= IDLE;
          else if (redirect_valid) pc <= redirect_addr;
          else if (start)          pc <= start_addr;
          else if (issue)          pc <= pc + 1'b1;
        end
        default: state <= IDLE;
      endcase

      rd_pending <= issue;
      if (issue) tag <= pc;

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset && push) begin
      data_mem[wr_ptr] <= pc_readdata;
      addr_mem[wr_ptr] <= tag;
    end
  end

  // The issue credit rule must make a push into a full FIFO impossible
  always_ff @(posedge clk_clk) begin
    if (!reset_reset) begin
      assert (!(push && !pop && count == CW'(DEPTH)));
    end
  end

endmodule

// File: tb/tb_pc_fetch_master.sv
// Randomized and directed bench for pc_fetch_master against a stream-level reference model.
module tb_pc_fetch_master;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset_reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          stop;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_addr;
  logic          busy;
  logic [AW-1:0] pc_address;
  logic          pc_chipselect;
  logic          pc_clken;
  logic          pc_write;
  logic [DW-1:0] pc_writedata;
  logic [3:0]    pc_byteenable;
  logic          pc_debugaccess;
  logic [DW-1:0] pc_readdata;

  always #5 clk = ~clk;

  pc_fetch_master #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk_clk(clk), .reset_reset(reset_reset),
    .start(start), .start_addr(start_addr), .stop(stop),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_addr(instr_addr), .busy(busy),
    .pc_address(pc_address), .pc_chipselect(pc_chipselect), .pc_clken(pc_clken),
    .pc_write(pc_write), .pc_writedata(pc_writedata), .pc_byteenable(pc_byteenable),
    .pc_debugaccess(pc_debugaccess), .pc_readdata(pc_readdata)
  );

  // On-chip RAM slave with read latency 1
  logic [DW-1:0] mem [32];
  always @(posedge clk) if (pc_chipselect) pc_readdata <= mem[pc_address];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: running flag plus the address the next delivered word must carry
  bit            m_run    = 0;
  logic [AW-1:0] exp_addr = '0;
  bit            hold_v   = 0;
  logic [AW-1:0] hold_a;
  logic [DW-1:0] hold_d;
  int            stall    = 0;
  int            pops     = 0;
  int            cs_cnt   = 0;
  bit            last_valid, last_cs;

  task automatic cycle(input bit st, input logic [AW-1:0] sa, input bit sp, input bit rv,
                       input logic [AW-1:0] ra, input bit rdy, input bit rst);
    bit ev;
    @(negedge clk);
    start = st; start_addr = sa; stop = sp; redirect_valid = rv;
    redirect_addr = ra; instr_ready = rdy; reset_reset = rst;
    #1;
    last_valid = instr_valid;
    last_cs    = pc_chipselect;
    if (pc_chipselect) cs_cnt++;
    ev = m_run && (sp || rv || st);

    check("const_out", {pc_clken, pc_write, pc_byteenable, pc_debugaccess, pc_writedata},
          {1'b1, 1'b0, 4'hF, 1'b0, 32'h0});
    check("busy", busy, m_run);
    if (!m_run) check("idle_valid", instr_valid, 0);
    if (!instr_valid) check("empty_out", {instr_addr, instr_data}, 0);
    if (!m_run || ev) check("cs_blocked", pc_chipselect, 0);
    if (hold_v) check("hold", {instr_addr, instr_data}, {hold_a, hold_d});
    if (instr_valid && rdy) begin
      check("addr", instr_addr, exp_addr);
      check("data", instr_data, mem[instr_addr]);
      exp_addr++;
      pops++;
    end
    if (m_run && !ev && !instr_valid) begin
      stall++;
      check("gap", stall <= 2, 1);
    end else begin
      stall = 0;
    end

    hold_v = instr_valid && !rdy && !rst && !ev;
    hold_a = instr_addr;
    hold_d = instr_data;

    if (rst) m_run = 0;
    else if (m_run) begin
      if (sp)      m_run = 0;
      else if (rv) exp_addr = ra;
      else if (st) exp_addr = sa;
    end else if (st) begin
      m_run = 1;
      exp_addr = sa;
      stall = 0;
    end
  endtask

  task automatic idle_cycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, '0, rdy, 0);
  endtask

  initial begin
    reset_reset = 1; start = 0; start_addr = '0; stop = 0;
    redirect_valid = 0; redirect_addr = '0; instr_ready = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;

    for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0, '0, 0, 1);
    idle_cycles(2, 1);
    check("rst_cs", last_cs, 0);

    // Start latency and sustained streaming
    cycle(1, 5'd0, 0, 0, '0, 1, 0);
    idle_cycles(1, 1); check("lat_cs", last_cs, 1); check("lat1", last_valid, 0);
    idle_cycles(1, 1); check("lat2", last_valid, 0);
    idle_cycles(1, 1); check("lat3", last_valid, 1);
    for (int i = 0; i < 5; i++) begin idle_cycles(1, 1); check("stream", last_valid, 1); end

    // Redirect to 20 while streaming
    cycle(0, '0, 0, 1, 5'd20, 1, 0);
    idle_cycles(1, 1); check("redir1", last_valid, 0);
    idle_cycles(1, 1); check("redir2", last_valid, 0);
    idle_cycles(1, 1); check("redir3", last_valid, 1);
    idle_cycles(4, 1);

    // Stop beats redirect, then restart at 12
    cycle(0, '0, 1, 1, 5'd3, 1, 0);
    idle_cycles(1, 1); check("stop_valid", last_valid, 0); check("stop_cs", last_cs, 0);
    cycle(1, 5'd12, 0, 0, '0, 1, 0);
    pops = 0;
    idle_cycles(6, 1);
    check("restart_pops", pops, 4);

    // Wrap 31 -> 0 without a gap
    cycle(0, '0, 1, 0, '0, 1, 0);
    cycle(1, 5'd30, 0, 0, '0, 1, 0);
    idle_cycles(2, 1);
    for (int i = 0; i < 6; i++) begin idle_cycles(1, 1); check("wrap_stream", last_valid, 1); end

    // Backpressure: only DEPTH reads may be issued
    cycle(0, '0, 1, 0, '0, 0, 0);
    cs_cnt = 0;
    cycle(1, 5'd4, 0, 0, '0, 0, 0);
    idle_cycles(10, 0);
    check("bp_cs", cs_cnt, DEPTH);
    check("bp_valid", last_valid, 1);
    pops = 0;
    idle_cycles(4, 1);
    check("bp_pops", pops, 4);

    // Reset mid-fetch
    idle_cycles(3, 1);
    cycle(0, '0, 0, 0, '0, 1, 1);
    idle_cycles(1, 1); check("rst_mid_valid", last_valid, 0); check("rst_mid_cs", last_cs, 0);
    idle_cycles(3, 1);

    // Random phase with fresh memory contents
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    for (int i = 0; i < 600; i++) begin
      int  r;
      bit  st, sp, rv, rst, rdy;
      r   = $urandom_range(99);
      st  = m_run ? (r < 3) : ($urandom_range(9) < 3);
      sp  = (r >= 3 && r < 5);
      rv  = (r >= 5 && r < 11);
      rst = (r == 99);
      rdy = ($urandom_range(9) < 7);
      cycle(st, AW'($urandom), sp, rv, AW'($urandom), rdy, rst);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
